// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE,
    RX_DONE
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver result bundle: the receiver drives it through master, the consumer reads it through slave.
// The parity_err signal exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_busy;
  logic                      frame_err;
`ifdef UART_RX_PARITY_EN
  logic                      parity_err;
`endif

  modport master (
    output rx_data, rx_valid, rx_busy, frame_err
`ifdef UART_RX_PARITY_EN
    , output parity_err
`endif
  );

  modport slave (
    input rx_data, rx_valid, rx_busy, frame_err
`ifdef UART_RX_PARITY_EN
    , input parity_err
`endif
  );

endinterface

// File: rtl/uart_rx_sync_ff.sv
// Multi-stage synchronizer for an asynchronous single-bit input.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= {STAGES{RESET_VAL}};
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
//
// state        | meaning
// RX_IDLE      | line idle, watching for a falling edge
// RX_START     | verifying start bit at its midpoint
// RX_DATA      | sampling 8 data bits, LSB first
// RX_PARITY    | sampling even-parity bit (parity build only)
// RX_STOP      | sampling stop bit
// RX_WAIT_IDLE | framing error seen, waiting for line high
// RX_DONE      | one-cycle result presentation
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      os_tick,
  input  logic      rx,
  uart_rx_if.master rx_if
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  rx_state_t                 state;
  logic [CNT_W-1:0]          tick_cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      rx_s;
  logic                      rx_s_d;
`ifdef UART_RX_PARITY_EN
  logic                      parity_bad;
`endif

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (UART_IDLE_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= RX_IDLE;
      tick_cnt        <= '0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      rx_s_d          <= UART_IDLE_LEVEL;
      rx_if.rx_data   <= '0;
      rx_if.rx_valid  <= 1'b0;
      rx_if.rx_busy   <= 1'b0;
      rx_if.frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_if.parity_err <= 1'b0;
      parity_bad       <= 1'b0;
`endif
    end else begin
      rx_s_d          <= rx_s;
      rx_if.rx_valid  <= 1'b0;
      rx_if.frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_if.parity_err <= 1'b0;
`endif
      case (state)
        RX_IDLE: begin
          if (rx_s_d && !rx_s) begin
            state         <= RX_START;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            rx_if.rx_busy <= 1'b1;
          end
        end

        RX_START: begin
          if (os_tick) begin
            if (tick_cnt == HALF_M1) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state <= RX_DATA;
              end else begin
                state         <= RX_IDLE;
                rx_if.rx_busy <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        RX_DATA: begin
          if (os_tick) begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt           <= '0;
              shift_reg[bit_cnt] <= rx_s;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= RX_PARITY;
`else
                state   <= RX_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (os_tick) begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt         <= '0;
              state            <= RX_STOP;
              parity_bad       <= (rx_s != ^shift_reg);
              rx_if.parity_err <= (rx_s != ^shift_reg);
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif

        RX_STOP: begin
          if (os_tick) begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state           <= RX_WAIT_IDLE;
                rx_if.frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (parity_bad) begin
                // bad parity with a good stop bit: drop the byte quietly
                state         <= RX_IDLE;
                rx_if.rx_busy <= 1'b0;
`endif
              end else begin
                state          <= RX_DONE;
                rx_if.rx_data  <= shift_reg;
                rx_if.rx_valid <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        RX_WAIT_IDLE: begin
          if (rx_s) begin
            state         <= RX_IDLE;
            tick_cnt      <= '0;
            rx_if.rx_busy <= 1'b0;
          end
        end

        RX_DONE: begin
          state         <= RX_IDLE;
          tick_cnt      <= '0;
          rx_if.rx_busy <= 1'b0;
        end

        default: begin
          state         <= RX_IDLE;
          tick_cnt      <= '0;
          rx_if.rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
